// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: bus widths, request bundle, FSM states.
// Also hosts the wait-counter width helper used by the timer.
package apb_master_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    APB_READ  = 1'b0,
    APB_WRITE = 1'b1
  } apb_rw_t;

  typedef struct packed {
    addr_t   paddr;
    apb_rw_t pwrite;
    data_t   pwdata;
  } apb_req_t;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;

  localparam int unsigned APB_TIMEOUT_DEFAULT = 16;

  // A disabled timeout still needs a 1-bit counter to stay legal.
  function automatic int unsigned wait_cnt_w(int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter with clear/enable.
// Flags when the count sits on the last allowed wait cycle.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned LIMIT = APB_TIMEOUT_DEFAULT,
  parameter int unsigned W     = wait_cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam logic [W-1:0] HIT_VAL =
    (LIMIT == 0) ? '0 : W'(LIMIT - 1);
  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_hit = (LIMIT != 0) && (r_cnt == HIT_VAL);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: IDLE -> SETUP -> ACCESS with
// optional ACCESS timeout and a one-cycle registered response pulse.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic     pclk,
  input  logic     presetn,
  input  logic     req_valid,
  output logic     req_ready,
  input  apb_req_t req_i,
  output logic     rsp_valid,
  output data_t    rsp_rdata,
  output logic     rsp_timeout,
  output logic     psel,
  output logic     penable,
  output logic     pwrite,
  output addr_t    paddr,
  output data_t    pwdata,
  input  data_t    prdata,
  input  logic     pready
);

  apb_state_t r_state;
  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  addr_t      r_paddr;
  data_t      r_pwdata;
  logic       r_rsp_valid;
  data_t      r_rsp_rdata;
  logic       r_rsp_timeout;

  logic w_idle;
  logic w_setup;
  logic w_access;
  logic w_accept;
  logic w_hit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_setup  = (r_state == ST_SETUP);
  assign w_access = (r_state == ST_ACCESS);
  assign w_accept = w_idle && req_valid;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (pclk),
    .rst_n (presetn),
    .i_clr (w_accept),
    .i_en  (w_access && !pready),
    .o_hit (w_hit)
  );

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state       <= ST_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (1'b1)
        w_idle: begin
          if (req_valid) begin
            r_state   <= ST_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= req_i.paddr;
            r_pwrite  <= req_i.pwrite;
            r_pwdata  <= req_i.pwdata;
          end
        end
        w_setup: begin
          r_state   <= ST_ACCESS;
          r_penable <= 1'b1;
        end
        w_access: begin
          // pready wins over a timeout landing in the same cycle
          if (pready) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_timeout <= 1'b0;
          end else if (w_hit) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = w_idle;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master with a 4-cycle timeout.
// Expected timing comes from a cycle-count model of the transfer rules.
module tb_apb_master;
  import apb_master_pkg::*;

  localparam int TO = 4;

  logic     pclk;
  logic     presetn;
  logic     req_valid;
  logic     req_ready;
  apb_req_t req_i;
  logic     rsp_valid;
  data_t    rsp_rdata;
  logic     rsp_timeout;
  logic     psel;
  logic     penable;
  logic     pwrite;
  addr_t    paddr;
  data_t    pwdata;
  data_t    prdata;
  logic     pready;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the most recent do_xfer call
  int    x_cyc;
  data_t x_rdata;
  logic  x_to;
  logic  x_stable;
  logic  x_proto;
  int    x_psel;
  int    x_pen;

  apb_master #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_i       (req_i),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Model: response cycle relative to the accept cycle (cycle 0)
  function automatic int exp_cyc(int waits);
    if (TO != 0 && waits >= TO) return TO + 2;
    return 3 + waits;
  endfunction

  function automatic logic exp_to(int waits);
    return (TO != 0 && waits >= TO);
  endfunction

  function automatic data_t exp_rd(logic wr, int waits, data_t rd);
    if (wr || exp_to(waits)) return '0;
    return rd;
  endfunction

  // Presents one request at the current negedge (cycle 0) and acts as
  // a slave holding pready low for `waits` ACCESS cycles.
  task automatic do_xfer(input addr_t a, input logic wr,
                         input data_t wd, input data_t rd,
                         input int waits);
    int n;
    n = 0;
    x_cyc = -1; x_rdata = 'x; x_to = 1'bx;
    x_stable = 1'b1; x_proto = 1'b1; x_psel = 0; x_pen = 0;
    req_valid = 1'b1;
    req_i = '{paddr: a, pwrite: apb_rw_t'(wr), pwdata: wd};
    for (int k = 1; k <= 40 && x_cyc < 0; k++) begin
      @(negedge pclk);
      if (k == 1) req_valid = 1'b0;
      pready = 1'b0;
      prdata = $urandom;
      if (psel) begin
        x_psel++;
        if (paddr !== a || pwrite !== wr || pwdata !== wd)
          x_stable = 1'b0;
      end
      if (penable) begin
        x_pen++;
        n++;
        if (n == waits + 1) begin
          pready = 1'b1;
          prdata = rd;
        end
      end
      if (penable && !psel) x_proto = 1'b0;
      if (k == 1 && (penable || !psel)) x_proto = 1'b0;
      if (req_ready === psel) x_proto = 1'b0;
      if (rsp_valid) begin
        x_cyc   = k;
        x_rdata = rsp_rdata;
        x_to    = rsp_timeout;
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_reset;
    logic [79:0] outs;
    presetn   = 1'b0;
    req_valid = 1'b1;
    req_i     = '{paddr: 10'h155, pwrite: APB_WRITE, pwdata: $urandom};
    pready    = 1'b0;
    prdata    = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge pclk);
      outs = {psel, penable, pwrite, paddr, pwdata,
              rsp_valid, rsp_rdata, rsp_timeout};
      n_checks++;
      if (outs !== '0) begin
        n_fail++;
        $display("FAIL reset_outs c%0d: got %h want 0", c, outs);
      end
    end
    presetn   = 1'b1;
    req_valid = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (req_ready !== 1'b1 || psel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b psel=%b want 1/0",
               req_ready, psel);
    end
  endtask

  task automatic test_write_zero_wait;
    data_t rd;
    rd = $urandom;
    do_xfer(10'h3A5, 1'b1, 32'hDEADBEEF, rd, 0);
    n_checks++;
    if (x_cyc !== 3) begin
      n_fail++;
      $display("FAIL wr0_cycle: got %0d want 3", x_cyc);
    end
    n_checks++;
    if (x_rdata !== '0 || x_to !== 1'b0) begin
      n_fail++;
      $display("FAIL wr0_rsp: got %h/%b want 0/0", x_rdata, x_to);
    end
    n_checks++;
    if (x_psel !== 2 || x_pen !== 1 || !x_stable || !x_proto) begin
      n_fail++;
      $display("FAIL wr0_bus: psel=%0d pen=%0d st=%b pr=%b want 2 1 1 1",
               x_psel, x_pen, x_stable, x_proto);
    end
  endtask

  // Three wait states with TO=4 also exercises the pready-wins boundary
  task automatic test_read_waits;
    do_xfer(10'h010, 1'b0, $urandom, 32'h12345678, 3);
    n_checks++;
    if (x_cyc !== 6) begin
      n_fail++;
      $display("FAIL rd3_cycle: got %0d want 6", x_cyc);
    end
    n_checks++;
    if (x_rdata !== 32'h12345678 || x_to !== 1'b0) begin
      n_fail++;
      $display("FAIL rd3_rsp: got %h/%b want 12345678/0", x_rdata, x_to);
    end
    n_checks++;
    if (!x_stable || !x_proto || x_pen !== 4) begin
      n_fail++;
      $display("FAIL rd3_bus: st=%b pr=%b pen=%0d want 1 1 4",
               x_stable, x_proto, x_pen);
    end
  endtask

  task automatic test_timeout;
    do_xfer(10'h2F0, 1'b0, $urandom, 32'hCAFEF00D, 1000);
    n_checks++;
    if (x_cyc !== TO + 2) begin
      n_fail++;
      $display("FAIL to_cycle: got %0d want %0d", x_cyc, TO + 2);
    end
    n_checks++;
    if (x_to !== 1'b1 || x_rdata !== '0) begin
      n_fail++;
      $display("FAIL to_rsp: got %b/%h want 1/0", x_to, x_rdata);
    end
    n_checks++;
    if (x_pen !== TO || !x_proto) begin
      n_fail++;
      $display("FAIL to_bus: pen=%0d pr=%b want %0d 1", x_pen, x_proto, TO);
    end
  endtask

  task automatic test_random;
    addr_t a;
    logic  wr;
    data_t wd;
    data_t rd;
    int    w;
    for (int i = 0; i < 12; i++) begin
      a  = addr_t'($urandom);
      wr = 1'($urandom);
      wd = $urandom;
      rd = $urandom;
      w  = $urandom_range(0, 6);
      do_xfer(a, wr, wd, rd, w);
      n_checks++;
      if (x_cyc !== exp_cyc(w) || x_to !== exp_to(w) ||
          x_rdata !== exp_rd(wr, w, rd)) begin
        n_fail++;
        $display("FAIL rand%0d_rsp: got c=%0d to=%b d=%h want %0d %b %h",
                 i, x_cyc, x_to, x_rdata,
                 exp_cyc(w), exp_to(w), exp_rd(wr, w, rd));
      end
      n_checks++;
      if (!x_stable || !x_proto || x_psel !== exp_cyc(w) - 1) begin
        n_fail++;
        $display("FAIL rand%0d_bus: st=%b pr=%b psel=%0d want 1 1 %0d",
                 i, x_stable, x_proto, x_psel, exp_cyc(w) - 1);
      end
      @(negedge pclk);
    end
  endtask

  task automatic test_back_to_back;
    apb_req_t q[4];
    data_t    rd[4];
    int       got_c[$];
    data_t    got_d[$];
    int       idx;
    logic     ok;
    idx = 0;
    ok  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q[i]  = '{paddr: addr_t'($urandom), pwrite: apb_rw_t'(i % 2),
                pwdata: $urandom};
      rd[i] = $urandom;
    end
    @(negedge pclk);
    for (int c = 0; c < 16; c++) begin
      if (rsp_valid) begin
        got_c.push_back(c);
        got_d.push_back(rsp_rdata);
      end
      if (req_ready === psel) ok = 1'b0;
      pready = psel && penable;
      prdata = (pready && got_c.size() < 4) ? rd[got_c.size()] : $urandom;
      if (req_ready && idx < 4) begin
        req_valid = 1'b1;
        req_i     = q[idx];
        idx++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end
      @(negedge pclk);
    end
    req_valid = 1'b0;
    pready    = 1'b0;
    n_checks++;
    if (got_c.size() !== 4 || !ok) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d rsp ok=%b want 4 1",
               got_c.size(), ok);
    end
    for (int i = 0; i < 4 && i < got_c.size(); i++) begin
      n_checks++;
      if (got_c[i] !== 3 * (i + 1) ||
          got_d[i] !== exp_rd(q[i].pwrite, 0, rd[i])) begin
        n_fail++;
        $display("FAIL b2b_rsp%0d: got c=%0d d=%h want %0d %h", i,
                 got_c[i], got_d[i], 3 * (i + 1),
                 exp_rd(q[i].pwrite, 0, rd[i]));
      end
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    @(negedge pclk);
    req_valid = 1'b1;
    req_i     = '{paddr: 10'h0AA, pwrite: APB_READ, pwdata: '0};
    @(negedge pclk);
    req_valid = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_access: psel=%b pen=%b want 1/1", psel, penable);
    end
    presetn = 1'b0;
    @(negedge pclk);
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drop: psel=%b pen=%b rv=%b want 0/0/0",
               psel, penable, rsp_valid);
    end
    presetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge pclk);
      if (rsp_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_norsp: got rsp_valid=%b want 0", seen);
    end
    do_xfer(10'h1C3, 1'b0, '0, 32'h0BADC0DE, 1);
    n_checks++;
    if (x_cyc !== 4 || x_rdata !== 32'h0BADC0DE || x_to !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_fresh: got c=%0d d=%h to=%b want 4 0badc0de 0",
               x_cyc, x_rdata, x_to);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    @(negedge pclk);
    test_read_waits();
    @(negedge pclk);
    test_timeout();
    @(negedge pclk);
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that turns single-beat requests from the system side into compliant APB SETUP/ACCESS transfers. It sits directly upstream of the dual-port memory's APB slave port and drives `psel`, `penable`, `paddr`, `pwrite` and `pwdata` into it. Each completed transfer returns read data plus a timeout flag. Transfers are strictly one at a time: one request in flight, no pipelining.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles with `pready` low before the transfer is aborted. 0 disables the timeout.

Ports:
- `pclk`  in  1  clock; one clock domain; all logic on the rising edge
- `presetn`  in  1  reset; synchronous, active-low
- `req_valid`  in  1  a request is presented
- `req_ready`  out  1  the block can accept a request
- `req_i`  in  `apb_req_t` (43)  request: `paddr`, `pwrite`, `pwdata`
- `rsp_valid`  out  1  one-cycle pulse marking a completed transfer
- `rsp_rdata`  out  `data_t` (32)  read data; 0 for writes and for timeouts
- `rsp_timeout`  out  1  the transfer was aborted by the timeout; qualified by `rsp_valid`
- `psel`, `penable`, `pwrite`  out  1 each  APB control
- `paddr`  out  `addr_t` (10)  APB address
- `pwdata`  out  `data_t` (32)  APB write data
- `prdata`  in  `data_t` (32)  APB read data
- `pready`  in  1  APB slave ready

## Operation
- FSM uses `apb_state_t`: IDLE, SETUP, ACCESS.
- `req_ready` = (state == IDLE). It is a combinational decode of the state register only; there is no path from `pready` or `req_valid` to it.
- IDLE:
  - On `req_valid && req_ready`: latch `req_i` into `paddr`/`pwrite`/`pwdata`; next state SETUP.
- SETUP:
  - `psel`=1, `penable`=0.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - `psel`=1, `penable`=1.
  - If `pready`=1: next state IDLE; `rsp_valid`=1 on the next cycle.
    - `rsp_rdata` = `prdata` for reads, 0 for writes.
    - `rsp_timeout`=0.
  - Else if timeout enabled and the wait counter reaches `TIMEOUT_CYCLES`-1: next state IDLE; `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Else stay in ACCESS and increment the wait counter.
- Wait counter:
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on entry to SETUP.
  - Saturates; it never wraps.
- `paddr`, `pwrite`, `pwdata` are stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- `rsp_valid` has no backpressure. The consumer must accept it in the cycle it is asserted.
- `req_i` is ignored whenever `req_ready`=0.

## Timing
- Reset (`presetn`=0 at an edge):
  - State goes to IDLE.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_timeout` = 0.
  - Wait counter = 0.
  - `req_ready`=1 from the first cycle after reset.
- Reset mid-transfer: the bus is dropped at the reset edge and no `rsp_valid` is issued for the aborted transfer.
- All APB and response outputs are registered.
- Zero-wait-state latency, counted from the accept edge at cycle 0:
  - SETUP in cycle 1.
  - ACCESS in cycle 2, with `pready` sampled at the end of cycle 2.
  - `rsp_valid` in cycle 3; `req_ready` is also 1 in cycle 3.
- Throughput: at most one transfer per 3 cycles. Each wait state adds one cycle.
- Timeout: `rsp_valid` with `rsp_timeout`=1 appears exactly `TIMEOUT_CYCLES`+2 cycles after acceptance.
- Boundary case: if `pready` rises in the same cycle the counter reaches its limit, `pready` wins and the transfer completes normally with `rsp_timeout`=0.
- `psel` deasserts for at least one cycle (IDLE) between consecutive transfers.

## Structure
- Shared package: reuse `addr_t`, `data_t`, `apb_req_t`, `apb_rw_t` and `apb_state_t`.
- Add `APB_TIMEOUT_DEFAULT = 16` to the package as the default for `TIMEOUT_CYCLES`.
- One sub-module: `apb_wait_timer`, a saturating counter with clear and enable that flags when the limit is reached.

## Test plan
- Reset: drive `presetn`=0 for 2 cycles with `req_valid`=1 -> all outputs 0, no transfer starts; `req_ready`=1 on the first cycle after release.
- Write, zero wait: `paddr`=0x3A5, `pwdata`=0xDEADBEEF, `pwrite`=1 -> `psel` in cycles 1–2, `penable` only in cycle 2; `rsp_valid` in cycle 3 with `rsp_rdata`=0 and `rsp_timeout`=0.
- Read, 3 wait states: `paddr`=0x010, `prdata`=0x12345678 presented together with `pready` in the 4th ACCESS cycle -> `rsp_rdata`=0x12345678 in cycle 6; address stable throughout.
- Timeout: `TIMEOUT_CYCLES`=4, `pready` held at 0 -> bus drops after 4 ACCESS cycles; `rsp_valid`=1, `rsp_timeout`=1, `rsp_rdata`=0 at cycle 6.
- Back-to-back: `req_valid` held high with 4 queued requests -> exactly 4 responses at cycles 3, 6, 9, 12; `req_ready` low during SETUP and ACCESS.
- Reset while in ACCESS -> `psel`=0 at the next edge and no `rsp_valid`; a fresh request afterwards completes normally.
